// File: rtl/base_pkg.sv
// Shared CPU-side types plus the timer register map and CTRL field layout.
package base;

    typedef logic [31:0] cpu_word;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_COUNT    = 3'd1,
        REG_COMPARE  = 3'd2,
        REG_STATUS   = 3'd3,
        REG_PRESCALE = 3'd4,
        REG_ID       = 3'd5,
        REG_CAPTURE  = 3'd6,
        REG_RSVD7    = 3'd7
    } timer_reg_e;

    localparam int TIMER_CTRL_EN   = 0;
    localparam int TIMER_CTRL_AUTO = 1;
    localparam int TIMER_CTRL_IRQ  = 2;

    localparam cpu_word TIMER_CTRL_RSVD_MASK = 32'hFFFF_FFF8;

endpackage

// File: rtl/mmap_region.sv
// Region bus between the CPU's region decoder (CTRL side) and a memory or peripheral responder (MEM side).
interface mmap_region;
    import base::*;

    logic        request_exec;
    logic        rw_request;
    logic        is_write;
    logic [23:0] address_rw;
    cpu_word     write_word;

    cpu_word     exec_word;
    cpu_word     read_word;
    logic        fault_exec;
    logic        fault_address;
    logic        fault_write;
    logic        fault_einval;
    logic        fault_read;
    logic        word_level_io;

    modport MEM (
        input  request_exec, rw_request, is_write, address_rw, write_word,
        output exec_word, read_word, fault_exec, fault_address, fault_write,
               fault_einval, fault_read, word_level_io
    );

    modport CTRL (
        output request_exec, rw_request, is_write, address_rw, write_word,
        input  exec_word, read_word, fault_exec, fault_address, fault_write,
               fault_einval, fault_read, word_level_io
    );

endinterface

// File: rtl/mmap_timer_prescaler.sv
// Programmable clock divider: one-cycle tick every (prescale+1) enabled cycles.
module timer_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] prescale,
    input  logic         restart,
    output logic         tick
);

    logic [W-1:0] cnt_reg;

    assign tick = enable && (cnt_reg == prescale);

    always_ff @(posedge clk) begin
        if (reset || !enable || restart || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

endmodule

// File: rtl/mmap_timer.sv
// Memory-mapped timer/compare peripheral on the MEM side of mmap_region.
// Define MMAP_TIMER_CAPTURE_EN to add the read-only CAPTURE register at index 6.
module mmap_timer
    import base::*;
#(
    parameter int      PRESCALE_W = 16,
    parameter cpu_word ID_VALUE   = 32'h544D_5231
) (
    input  logic      clk,
    input  logic      reset,
    mmap_region.MEM   bus,
    output logic      irq
);

`ifdef MMAP_TIMER_CAPTURE_EN
    localparam bit CAPTURE_EN = 1'b1;
    cpu_word capture_reg;
`else
    localparam bit CAPTURE_EN = 1'b0;
`endif

    timer_reg_e            idx;
    logic                  out_of_range;
    logic                  fault_addr, fault_wr, fault_inval, any_fault;
    logic                  wr_en, tick, hit;
    cpu_word               rd_mux;
    logic [2:0]            ctrl_reg;
    cpu_word               count_reg, compare_reg;
    logic                  match_reg, irq_reg;
    logic [PRESCALE_W-1:0] prescale_reg;
    logic                  unused_addr_bits;

    // Word-only bus: byte-lane bits carry no meaning here.
    assign unused_addr_bits = ^bus.address_rw[1:0];

    assign idx          = timer_reg_e'(bus.address_rw[4:2]);
    assign out_of_range = |bus.address_rw[23:5];

    assign fault_addr  = bus.rw_request && (out_of_range || idx == REG_RSVD7 ||
                         (idx == REG_CAPTURE && !CAPTURE_EN));
    assign fault_wr    = bus.rw_request && bus.is_write && !out_of_range &&
                         (idx == REG_ID || (CAPTURE_EN && idx == REG_CAPTURE));
    assign fault_inval = bus.rw_request && bus.is_write && !out_of_range && idx == REG_CTRL &&
                         |(bus.write_word & TIMER_CTRL_RSVD_MASK);
    assign any_fault   = fault_addr || fault_wr || fault_inval;
    assign wr_en       = bus.rw_request && bus.is_write && !any_fault;

    always_comb begin
        rd_mux = '0;
        case (idx)
            REG_CTRL:     rd_mux = {29'd0, ctrl_reg};
            REG_COUNT:    rd_mux = count_reg;
            REG_COMPARE:  rd_mux = compare_reg;
            REG_STATUS:   rd_mux = {31'd0, match_reg};
            REG_PRESCALE: rd_mux = cpu_word'(prescale_reg);
            REG_ID:       rd_mux = ID_VALUE;
`ifdef MMAP_TIMER_CAPTURE_EN
            REG_CAPTURE:  rd_mux = capture_reg;
`endif
            default:      rd_mux = '0;
        endcase
    end

    assign bus.read_word     = (bus.rw_request && !any_fault) ? rd_mux : '0;
    assign bus.fault_exec    = bus.request_exec;
    assign bus.fault_address = fault_addr;
    assign bus.fault_write   = fault_wr;
    assign bus.fault_einval  = fault_inval;
    assign bus.fault_read    = 1'b0;
    assign bus.word_level_io = 1'b1;
    assign bus.exec_word     = '0;
    assign irq               = irq_reg;

    timer_prescaler #(.W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (ctrl_reg[TIMER_CTRL_EN]),
        .prescale (prescale_reg),
        .restart  (wr_en && idx == REG_PRESCALE),
        .tick     (tick)
    );

    assign hit = tick && (count_reg == compare_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_reg     <= '0;
            count_reg    <= '0;
            compare_reg  <= '0;
            match_reg    <= 1'b0;
            prescale_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            if (wr_en && idx == REG_CTRL)     ctrl_reg     <= bus.write_word[2:0];
            if (wr_en && idx == REG_COMPARE)  compare_reg  <= bus.write_word;
            if (wr_en && idx == REG_PRESCALE) prescale_reg <= bus.write_word[PRESCALE_W-1:0];
            // A software COUNT write overrides the tick update in the same cycle.
            if (wr_en && idx == REG_COUNT) begin
                count_reg <= bus.write_word;
            end else if (tick) begin
                count_reg <= (hit && ctrl_reg[TIMER_CTRL_AUTO]) ? '0 : count_reg + 32'd1;
            end
            // A new match beats a simultaneous write-1-to-clear.
            if (hit) begin
                match_reg <= 1'b1;
            end else if (wr_en && idx == REG_STATUS && bus.write_word[0]) begin
                match_reg <= 1'b0;
            end
            irq_reg <= match_reg && ctrl_reg[TIMER_CTRL_IRQ];
        end
    end

`ifdef MMAP_TIMER_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            capture_reg <= '0;
        end else if (hit) begin
            capture_reg <= count_reg;
        end
    end
`endif

endmodule

// File: tb/tb_mmap_timer.sv
// Scoreboard bench for mmap_timer: driver queues expected responses, a negedge monitor checks them.
module tb_mmap_timer;
    import base::*;

    localparam logic [23:0] A_CTRL = 24'h00, A_COUNT = 24'h04, A_CMP = 24'h08, A_STAT = 24'h0C;
    localparam logic [23:0] A_PRE = 24'h10, A_ID = 24'h14, A_CAP = 24'h18, A_R7 = 24'h1C;
    localparam logic [31:0] ID_EXP = 32'h544D_5231;

    typedef struct {
        string       name;
        bit          chk_rd;
        logic [31:0] rd;
        logic [4:0]  flt;
        bit          chk_irq;
        bit          irq;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic irq;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [4:0] mon_f;
    bit   mon_ok;
    int   n_cmp = 0;
    int   n_bad = 0;

    mmap_region bus_if();

    mmap_timer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic clear_bus();
        bus_if.request_exec = 1'b0;
        bus_if.rw_request   = 1'b0;
        bus_if.is_write     = 1'b0;
        bus_if.address_rw   = '0;
        bus_if.write_word   = '0;
    endtask

    task automatic op(input bit wr, input bit ex, input logic [23:0] addr, input logic [31:0] wd,
                      input bit chk_rd, input logic [31:0] rd, input logic [4:0] flt,
                      input bit chk_irq, input bit irq_e, input string nm);
        exp_t e;
        @(posedge clk); #1;
        bus_if.request_exec = ex;
        bus_if.rw_request   = !ex;
        bus_if.is_write     = wr;
        bus_if.address_rw   = addr;
        bus_if.write_word   = wd;
        e.name = nm; e.chk_rd = chk_rd; e.rd = rd; e.flt = flt; e.chk_irq = chk_irq; e.irq = irq_e;
        sb_q.push_back(e);
    endtask

    task automatic W(input logic [23:0] a, input logic [31:0] d, input string nm);
        op(1, 0, a, d, 0, 0, 5'b0, 0, 0, nm);
    endtask
    task automatic WI(input logic [23:0] a, input logic [31:0] d, input bit i, input string nm);
        op(1, 0, a, d, 0, 0, 5'b0, 1, i, nm);
    endtask
    task automatic WF(input logic [23:0] a, input logic [31:0] d, input logic [4:0] f, input string nm);
        op(1, 0, a, d, 1, 0, f, 0, 0, nm);
    endtask
    task automatic R(input logic [23:0] a, input logic [31:0] x, input string nm);
        op(0, 0, a, 0, 1, x, 5'b0, 0, 0, nm);
    endtask
    task automatic RI(input logic [23:0] a, input logic [31:0] x, input bit i, input string nm);
        op(0, 0, a, 0, 1, x, 5'b0, 1, i, nm);
    endtask
    task automatic RF(input logic [23:0] a, input logic [4:0] f, input string nm);
        op(0, 0, a, 0, 1, 0, f, 0, 0, nm);
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            clear_bus();
        end
    endtask

    // Monitor: every cycle the DUT is asked something, its response is compared to the queue head.
    always @(negedge clk) begin
        if (!reset && (bus_if.rw_request || bus_if.request_exec)) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_response: got rd=%h with no expectation queued", bus_if.read_word);
            end else begin
                mon_e = sb_q.pop_front();
                mon_f = {bus_if.fault_exec, bus_if.fault_address, bus_if.fault_write,
                         bus_if.fault_einval, bus_if.fault_read};
                mon_ok = (mon_f === mon_e.flt) && (bus_if.word_level_io === 1'b1) &&
                         (bus_if.exec_word === 32'd0) &&
                         (!mon_e.chk_rd || bus_if.read_word === mon_e.rd) &&
                         (!mon_e.chk_irq || irq === mon_e.irq);
                if (!mon_ok) begin
                    n_bad++;
                    $display("FAIL %s: got rd=%h flt=%b irq=%b wlio=%b exec=%h, want rd=%h flt=%b irq=%b",
                             mon_e.name, bus_if.read_word, mon_f, irq, bus_if.word_level_io,
                             bus_if.exec_word, mon_e.rd, mon_e.flt, mon_e.irq);
                end else begin
                    $display("ok   %-22s rd=%h flt=%b irq=%b", mon_e.name, bus_if.read_word, mon_f, irq);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_bus();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        RI(A_ID, ID_EXP, 0, "reset_id");
        R(A_CTRL, 32'd0, "reset_ctrl");
        R(A_COUNT, 32'd0, "reset_count");
        R(A_STAT, 32'd0, "reset_status");
        R(A_PRE, 32'd0, "reset_prescale");

        // Prescale 0, compare 3, enable+auto+irq
        W(A_PRE, 32'd0, "b_pre");
        W(A_CMP, 32'd3, "b_cmp");
        W(A_CTRL, 32'h7, "b_ctrl");
        R(A_COUNT, 32'd0, "b_count0");
        R(A_COUNT, 32'd1, "b_count1");
        R(A_COUNT, 32'd2, "b_count2");
        R(A_COUNT, 32'd3, "b_count3");
        RI(A_COUNT, 32'd0, 0, "b_reload_irq0");
        RI(A_STAT, 32'd1, 1, "b_match_irq1");
        WI(A_CTRL, 32'h6, 1, "b_disable");
        WI(A_STAT, 32'd1, 1, "b_w1c");
        RI(A_STAT, 32'd0, 1, "b_cleared_irq_lag");
        RI(A_STAT, 32'd0, 0, "b_irq_fell");
        R(A_COUNT, 32'd3, "b_count_frozen");

        // Prescale 2, no auto-reload, compare 1
        W(A_COUNT, 32'd0, "c_count");
        W(A_PRE, 32'd2, "c_pre");
        W(A_CMP, 32'd1, "c_cmp");
        W(A_CTRL, 32'h1, "c_ctrl");
        R(A_COUNT, 32'd0, "c_cnt_a");
        R(A_COUNT, 32'd0, "c_cnt_b");
        R(A_COUNT, 32'd0, "c_cnt_c");
        R(A_COUNT, 32'd1, "c_cnt_d");
        R(A_COUNT, 32'd1, "c_cnt_e");
        R(A_COUNT, 32'd1, "c_cnt_f");
        RI(A_STAT, 32'd1, 0, "c_match_noirq");
        R(A_COUNT, 32'd2, "c_cnt_g");
        R(A_COUNT, 32'd2, "c_cnt_h");
        RI(A_COUNT, 32'd3, 0, "c_past_cmp");

        // Faults
        W(A_CTRL, 32'h0, "d_stop");
        WF(A_ID, 32'h1234_5678, 5'b00100, "d_write_id");
        R(A_ID, ID_EXP, "d_id_kept");
        WF(A_CTRL, 32'h8, 5'b00010, "d_ctrl_rsvd");
        R(A_CTRL, 32'd0, "d_ctrl_kept");
        RF(24'h000020, 5'b01000, "d_oor");
        RF(24'h800000, 5'b01000, "d_oor_high");
        RF(A_R7, 5'b01000, "d_idx7");
        op(0, 1, 24'h0, 32'd0, 1, 32'd0, 5'b10000, 0, 0, "d_exec");

        // Tick and COUNT write collide; wrap at all-ones
        W(A_PRE, 32'd0, "e_pre");
        W(A_CMP, 32'hFFFF, "e_cmp");
        W(A_STAT, 32'd1, "e_clear");
        W(A_CTRL, 32'h1, "e_ctrl");
        W(A_COUNT, 32'h100, "e_count_vs_tick");
        R(A_COUNT, 32'h100, "e_write_won");
        W(A_COUNT, 32'hFFFF_FFFF, "e_count_max");
        R(A_COUNT, 32'hFFFF_FFFF, "e_at_max");
        R(A_COUNT, 32'd0, "e_wrapped");
        R(A_STAT, 32'd0, "e_no_wrap_match");

        // Clear and match in the same cycle
        W(A_CTRL, 32'h0, "e3_stop");
        W(A_COUNT, 32'd0, "e3_count");
        W(A_CMP, 32'd0, "e3_cmp");
        W(A_CTRL, 32'h3, "e3_ctrl");
        idle(1);
        W(A_STAT, 32'd1, "e3_clear_vs_set");
        R(A_STAT, 32'd1, "e3_set_won");
        R(A_COUNT, 32'd0, "e3_auto_reload");

        // Capture register (or unmapped slot 6)
        W(A_CTRL, 32'h0, "f_stop");
        W(A_COUNT, 32'd5, "f_count");
        W(A_CMP, 32'd5, "f_cmp");
        W(A_STAT, 32'd1, "f_clear");
        W(A_CTRL, 32'h1, "f_ctrl");
        idle(1);
        R(A_STAT, 32'd1, "f_match");
`ifdef MMAP_TIMER_CAPTURE_EN
        R(A_CAP, 32'd5, "f_capture");
        WF(A_CAP, 32'd9, 5'b00100, "f_capture_ro");
`else
        RF(A_CAP, 5'b01000, "f_idx6_unmapped");
        WF(A_CAP, 32'd9, 5'b01000, "f_idx6_write");
`endif
        R(A_COUNT, 32'd9, "f_count_run");

        // Reset mid-operation with a write in flight
        @(posedge clk); #1;
        reset = 1'b1;
        bus_if.rw_request = 1'b1;
        bus_if.is_write   = 1'b1;
        bus_if.address_rw = A_COUNT;
        bus_if.write_word = 32'h55;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_bus();
        RI(A_CTRL, 32'd0, 0, "g_ctrl");
        R(A_COUNT, 32'd0, "g_count");
        R(A_STAT, 32'd0, "g_status");
        R(A_CMP, 32'd0, "g_compare");
        R(A_PRE, 32'd0, "g_prescale");

        idle(2);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmap_timer.md
Name: mmap_timer

Overview:
- Memory-mapped timer/compare peripheral; responder on the MEM side of the `mmap_region` bus.
- The bus controller issues word reads/writes into a small register file.
- The block runs a prescaled up-counter, flags compare matches, and raises a level interrupt.
- Sits beside RAM/ROM regions behind the CPU's region decoder; word-level IO only.

Parameters:
- PRESCALE_W, 16, width of the prescaler divider register and counter.
- ID_VALUE, 32'h544D_5231, constant returned by the read-only ID register.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- bus  modport  mmap_region.MEM  region interface; block drives exec_word, read_word, the five fault_* outputs and word_level_io.
- irq  output  1  level interrupt = STATUS.match & CTRL.irq_en, registered.

Behaviour:
- Register index idx = address_rw[4:2]. address_rw[23:5] != 0 is out of range.
- Registers:
  - 0 CTRL rw: bit0 enable, bit1 auto_reload, bit2 irq_en; bits [31:3] reserved.
  - 1 COUNT rw.
  - 2 COMPARE rw.
  - 3 STATUS: bit0 match, write-1-to-clear.
  - 4 PRESCALE rw, low PRESCALE_W bits; upper bits read 0.
  - 5 ID ro.
  - 6, 7 unmapped.
- Reset: CTRL, COUNT, COMPARE, STATUS, PRESCALE, prescale counter and irq all 0.
- Static outputs: word_level_io = 1 constant; exec_word = 0 constant.
- Reads: read_word is combinational from idx, zero-latency, valid whenever rw_request=1 and no fault. read_word = 0 on fault or when rw_request=0.
- Faults are combinational, asserted only while the corresponding request is high:
  - fault_exec = request_exec; no execution from a peripheral.
  - fault_address: rw_request and (out of range or idx in {6,7}).
  - fault_write: write to ID.
  - fault_einval: write to CTRL with any reserved bit set.
  - fault_read = 0.
- Any faulting write is dropped with no state change.
- Writes commit on the rising clk edge where rw_request & is_write & no fault; one-cycle commit, visible on the read path the following cycle.
- Prescaler:
  - With enable=1, the prescale counter increments each cycle.
  - When it equals PRESCALE it resets to 0 and emits a one-cycle tick.
  - PRESCALE=0 therefore gives a tick every cycle.
  - With enable=0 the prescale counter holds 0 and no ticks occur.
- On tick:
  - If COUNT == COMPARE: set match; COUNT <= auto_reload ? 0 : COUNT+1.
  - Otherwise COUNT <= COUNT+1.
  - COUNT wraps 32'hFFFF_FFFF -> 0 silently; no match is implied by the wrap.
- Simultaneous events:
  - Software write to COUNT and tick in the same cycle: the write wins; the tick's increment is lost.
  - Write-1-clear to STATUS and a match set in the same cycle: the set wins, so match stays 1.
  - Writing PRESCALE resets the prescale counter to 0.
  - Clearing enable mid-count: COUNT holds its value.
- irq is registered: rises one cycle after match is set (if irq_en), falls one cycle after clear.
- Reset mid-operation returns all state to reset values on that edge; an in-flight write in the reset cycle is discarded.

Optional Feature:
- Macro: MMAP_TIMER_CAPTURE_EN.
- Defined:
  - idx 6 is CAPTURE (ro), reset 0, loaded with COUNT's pre-update value on every match.
  - Write to CAPTURE -> fault_write; read is legal.
- Undefined: idx 6 is unmapped -> fault_address; no capture flop is synthesized.

Decomposition:
- Package `base` gains:
  - timer_reg_e enum of register indices.
  - CTRL bit-position localparams (TIMER_CTRL_EN, TIMER_CTRL_AUTO, TIMER_CTRL_IRQ).
  - TIMER_CTRL_RSVD_MASK.
- cpu_word is reused from `base`.
- Sub-module timer_prescaler (inputs: enable, prescale value, restart; output: tick). It is natural because the divider is reusable by future UART/PWM regions.
- The top level holds the register file, decode and fault logic.

Test Plan:
- Reset, then read ID, CTRL, COUNT -> 32'h544D_5231, 0, 0. No faults; word_level_io=1.
- Write PRESCALE=0, COMPARE=3, CTRL=32'h7 -> match set after 4 ticks, COUNT back to 0. irq=1 one cycle after match; writing STATUS=1 clears irq on the next cycle.
- Write PRESCALE=2, CTRL=1 (no auto-reload), COMPARE=1 -> COUNT increments every 3rd cycle and passes 2 without reload; match=1, irq stays 0.
- Write ID -> fault_write=1 and ID unchanged. Write CTRL=32'h8 -> fault_einval=1 and CTRL unchanged. Read address 24'h000020 -> fault_address=1, read_word=0. Assert request_exec -> fault_exec=1.
- Edge cases: same-cycle tick and COUNT write of 32'h100 -> COUNT=32'h100. Same-cycle STATUS clear and match set -> match stays 1. COUNT=32'hFFFF_FFFF with tick -> 0.
- With MMAP_TIMER_CAPTURE_EN defined, COMPARE=5 match -> CAPTURE reads 5. Without the macro, a read at idx 6 -> fault_address=1.
